// File: rtl/fir_tm_mac.sv
// Time-multiplexed N-tap FIR: one multiplier, N MAC cycles per sample, result N+1 cycles after accept.
// in_ready drops while a sample is in flight; out_data is held until out_ready takes it.
module fir_tm_mac #(
  parameter int N   = 64,
  parameter int WIC = 1,
  parameter int WFC = 15,
  parameter int WID = 1,
  parameter int WFD = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N*(WIC+WFC)-1:0]   coeffs_full,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WID+WFD-1:0]       in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WID+WFD-1:0]       out_data
);

  localparam int WC = WIC + WFC;
  localparam int WD = WID + WFD;
  localparam int P  = WC + WD;
  localparam int AW = $clog2(N);
  localparam int WA = P + AW;
  localparam int WS = WA - WFC;

  localparam logic signed [WA-1:0] HALF = {{(WA-1){1'b0}}, 1'b1} << (WFC - 1);
  localparam logic signed [WS-1:0] MAXV = {{(WS-WD+1){1'b0}}, {(WD-1){1'b1}}};
  localparam logic signed [WS-1:0] MINV = {{(WS-WD+1){1'b1}}, {(WD-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                 state;
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          base;
  logic [AW-1:0]          k;
  logic signed [WA-1:0]   acc;
  logic signed [WD-1:0]   dline [N];

  logic [AW-1:0]          rd_addr;
  logic signed [WC-1:0]   coef;
  logic signed [WD-1:0]   samp;
  logic signed [P-1:0]    prod;
  logic signed [WA-1:0]   sum;
  logic signed [WA-1:0]   rnd;
  logic signed [WS-1:0]   shifted;
  logic [WD-1:0]          sat;

  // Newest sample pairs with c[0]; the log2(N)-bit subtraction wraps the circular buffer.
  always_comb begin
    rd_addr = base - k;
    coef    = coeffs_full[k*WC +: WC];
    samp    = dline[rd_addr];
    prod    = coef * samp;
    sum     = acc + WA'(prod);
    rnd     = sum + HALF;
    shifted = WS'(rnd >>> WFC);
    sat     = shifted[WD-1:0];
    if (shifted > MAXV)
      sat = MAXV[WD-1:0];
    else if (shifted < MINV)
      sat = MINV[WD-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      base      <= '0;
      k         <= '0;
      acc       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int i = 0; i < N; i++)
        dline[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dline[wr_ptr] <= in_data;
            base          <= wr_ptr;
            wr_ptr        <= wr_ptr + 1'b1;
            acc           <= '0;
            k             <= '0;
            in_ready      <= 1'b0;
            state         <= MAC;
          end
        end
        MAC: begin
          acc <= sum;
          k   <= k + 1'b1;
          // Last tap: convert the completed sum directly so OUT starts with a final result.
          if (k == AW'(N - 1)) begin
            out_data  <= sat;
            out_valid <= 1'b1;
            state     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fir_tm_mac.md
Name: fir_tm_mac

Overview:
Time-multiplexed FIR datapath that consumes the packed coefficient bus from the coefficient ROM and filters a sample stream with a single multiplier.
- Each accepted input sample is written into an N-deep circular delay line.
- The block then performs N sequential multiply-accumulates, one per clock.
- The rounded, saturated result is presented on a valid/ready output port.
- Sits between the sample source (ADC/stream interface) and the downstream output sink.

Parameters:
N, 64, number of taps; must equal the coefficient ROM's N; power of two, at least 2
WIC, 1, coefficient integer bits (sign included)
WFC, 15, coefficient fractional bits
WID, 1, input/output sample integer bits (sign included)
WFD, 15, input/output sample fractional bits

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
coeffs_full  in  N*(WIC+WFC)  packed coefficients; c[k] = coeffs_full[(k+1)*(WIC+WFC)-1 : k*(WIC+WFC)], signed
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample
in_data  in  WID+WFD  signed input sample
out_valid  out  1  output result valid
out_ready  in  1  downstream accepts result
out_data  out  WID+WFD  signed filtered output sample

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, wr_ptr=0, tap counter k=0, acc=0.
  - All N delay-line entries cleared to 0.
  - out_valid=0, out_data=0, in_ready=1 (asserted once reset releases).
  - Reset asserted mid-MAC or mid-OUT aborts the computation; no partial result is ever emitted.
- FSM states: IDLE, MAC, OUT.
  - IDLE: in_ready=1. On in_valid&&in_ready at edge T: x[wr_ptr]<=in_data, latch base=wr_ptr, wr_ptr<=wr_ptr+1 mod N, acc<=0, k<=0, go to MAC.
  - MAC: in_ready=0. Each cycle: acc <= acc + c[k]*x[(base-k) mod N]; k<=k+1. When k==N-1, the accumulation completes and the FSM goes to OUT. Exactly N MAC cycles (T+1 .. T+N).
  - OUT: out_valid=1 from cycle T+N+1. out_data is held stable while out_valid=1 and out_ready=0. On out_valid&&out_ready: out_valid<=0, go to IDLE.
- Latency: accept to first out_valid = N+1 cycles. Throughput: at most one sample per N+2 cycles.
- Simultaneous events:
  - in_valid is ignored outside IDLE.
  - A handshake in OUT plus in_valid in the same cycle: the new sample is not accepted until the next cycle, when the FSM is back in IDLE.
- Address wrap: (base-k) mod N uses unsigned log2(N)-bit subtraction, which wraps naturally. wr_ptr wraps N-1 -> 0.
- Arithmetic:
  - Product width is P = WIC+WFC+WID+WFD, with WFC+WFD fractional bits (signed full precision).
  - Accumulator width is P + log2(N) guard bits, so internal overflow is impossible.
- Output conversion, performed once on entering OUT:
  - Round half-up: add 2^(WFC-1).
  - Arithmetic shift right by WFC.
  - Saturate to a signed WID+WFD result: values above max go to 0x7FFF, values below min go to 0x8000 (defaults).
- coeffs_full is treated as static. Changes during MAC affect only the taps not yet processed.

Test Plan:
- Reset check: hold rst_n=0 -> out_valid=0, out_data=0x0000. After release, in_ready=1 and all delay-line entries read 0.
- Ramp/step: all c[k]=0x0100, feed in_data=0x0100 continuously with out_ready=1 -> j-th output (j=1..64) equals 2*j (0x0002 ... 0x0080), then stays 0x0080. out_valid is seen exactly 65 cycles after each accept.
- Impulse: c[k]=0x4000 for k even and 0x0000 for k odd; feed 0x7FFF then 63 zeros -> outputs alternate 0x4000, 0x0000, repeating.
- Saturation: all c=0x8000 with all inputs 0x8000 -> 64th output 0x7FFF. All c=0x7FFF with inputs 0x8000 -> 64th output 0x8000.
- Backpressure: hold out_ready=0 for 10 cycles in OUT -> out_valid stays 1, out_data stable, in_ready=0. Raising out_ready gives a single handshake, then in_ready=1 the next cycle.
- Mid-op reset: assert rst_n=0 at MAC cycle 30 -> no out_valid ever appears for that sample. The next sample after reset produces a result computed with a zeroed history (c[0]*x only).
